// File: rtl/regfile_mp.sv
// ----------------------------------------------------------------------------
// regfile_mp : multi-read-port register file with a self-clearing sweep
//
// A reset starts a sweep that writes zero into every entry, one entry per
// clock cycle. Once the last entry is cleared the file reports ready and
// accepts writes and reads. Each read port returns the addressed entry
// one clock after its address is presented.
//
// Optional build macro:
//   REGFILE_BYPASS_EN - when defined, a read that hits the entry being
//                       written in the same cycle returns the new write
//                       data instead of the stored value.
//
// Parameters:
//   WIDTH    - bits per entry
//   DEPTH    - number of entries (power of two, >= 2)
//   NREAD    - number of read ports (>= 1)
//   ZERO_REG - 1: entry 0 always reads as zero and ignores writes
//
// Ports:
//   clk      in   clock, everything changes on its rising edge
//   rst      in   synchronous active-high reset, restarts the clear sweep
//   wr_en    in   write request (ignored while clearing)
//   wr_addr  in   write index
//   wr_data  in   write value
//   rd_addr  in   read indices, port k at [k*AW +: AW]
//   rd_data  out  registered read results, port k at [k*WIDTH +: WIDTH]
//   ready    out  high once the clear sweep has finished
// ----------------------------------------------------------------------------
module regfile_mp #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic [NREAD*AW-1:0]    rd_addr,
  output logic [NREAD*WIDTH-1:0] rd_data,
  output logic                   ready
);

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [AW-1:0]          sweepCnt_q, sweepCnt_d;
  logic [NREAD*WIDTH-1:0] rdData_q, rdData_d;

  logic [WIDTH-1:0]       mem [DEPTH];

  logic                   memWe;
  logic [AW-1:0]          memAddr;
  logic [WIDTH-1:0]       memData;

  // Control state and registered read data. Reset forces the sweep to
  // restart from entry 0 and blanks every read port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= CLEAR;
      sweepCnt_q <= '0;
      rdData_q   <= '0;
    end else begin
      state_q    <= state_d;
      sweepCnt_q <= sweepCnt_d;
      rdData_q   <= rdData_d;
    end
  end

  // Next-state and write-port steering. While clearing, the write port is
  // taken over by the sweep so user writes are dropped; the machine leaves
  // CLEAR on the same edge that zeroes the last entry.
  always_comb begin
    state_d    = state_q;
    sweepCnt_d = sweepCnt_q;
    memWe      = 1'b0;
    memAddr    = wr_addr;
    memData    = wr_data;
    case (state_q)
      CLEAR: begin
        memWe      = 1'b1;
        memAddr    = sweepCnt_q;
        memData    = '0;
        sweepCnt_d = sweepCnt_q + AW'(1);
        if (sweepCnt_q == AW'(DEPTH - 1)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        memWe = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  // Storage array. No reset here: the sweep is what clears it. A write is
  // suppressed on a reset edge so the sweep always starts from a clean slate.
  always_ff @(posedge clk) begin
    if (!rst && memWe) begin
      mem[memAddr] <= memData;
    end
  end

  // Read-port next values. The array is sampled before this edge's write
  // lands, so a same-cycle collision returns the old value unless the
  // bypass path is compiled in.
  always_comb begin
    rdData_d = '0;
    for (int k = 0; k < NREAD; k++) begin
      logic [AW-1:0]    addr;
      logic [WIDTH-1:0] val;
      addr = rd_addr[k*AW +: AW];
      val  = mem[addr];
`ifdef REGFILE_BYPASS_EN
      if (wr_en && (addr == wr_addr)) begin
        val = wr_data;
      end
`endif
      if ((ZERO_REG != 0) && (addr == '0)) begin
        val = '0;
      end
      if (state_q != RUN) begin
        val = '0;
      end
      rdData_d[k*WIDTH +: WIDTH] = val;
    end
  end

  assign rd_data = rdData_q;
  assign ready   = (state_q == RUN);

endmodule

// File: tb/tb_regfile_mp.sv
// ----------------------------------------------------------------------------
// tb_regfile_mp : self-checking bench for regfile_mp (default parameters)
//
// A behavioural reference keeps the register contents as a plain array and
// tracks how many cycles have passed since reset was released. Every clock
// the bench predicts ready and both read ports from that reference and
// compares them with the design; directed scenarios also compare against
// literal constants.
// ----------------------------------------------------------------------------
module tb_regfile_mp;

  localparam int WIDTH = 32;
  localparam int DEPTH = 32;
  localparam int NREAD = 2;
  localparam int AW    = 5;

  logic                   clk;
  logic                   rst;
  logic                   wrEn;
  logic [AW-1:0]          wrAddr;
  logic [WIDTH-1:0]       wrData;
  logic [NREAD*AW-1:0]    rdAddr;
  logic [NREAD*WIDTH-1:0] rdData;
  logic                   ready;

  // Reference model state
  logic [WIDTH-1:0]       refMem [DEPTH];
  int                     cyclesSinceRst;
  bit                     refReady;
  logic [WIDTH-1:0]       expRd [NREAD];

  int                     checkCount;
  int                     passCount;

  regfile_mp #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .NREAD(NREAD), .ZERO_REG(1)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData),
    .rd_addr(rdAddr), .rd_data(rdData), .ready(ready)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports one check
  task automatic checkOutput(input string tag, input logic [WIDTH-1:0] obs,
                             input logic [WIDTH-1:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [WIDTH-1:0] portData(input int k);
    return rdData[k*WIDTH +: WIDTH];
  endfunction

  // Predict the outcome of the coming edge from the reference, advance one
  // clock, compare, and then let the reference absorb the edge.
  task automatic applyStimulus();
    logic            nextReady;
    logic [AW-1:0]   a;
    bit              doWrite;
    nextReady = refReady;
    doWrite   = 1'b0;
    if (rst) begin
      nextReady      = 1'b0;
      cyclesSinceRst = 0;
      for (int k = 0; k < NREAD; k++) expRd[k] = '0;
    end else if (!refReady) begin
      cyclesSinceRst++;
      if (cyclesSinceRst == DEPTH) nextReady = 1'b1;
      for (int k = 0; k < NREAD; k++) expRd[k] = '0;
    end else begin
      for (int k = 0; k < NREAD; k++) begin
        a = rdAddr[k*AW +: AW];
        if (a == 0) expRd[k] = '0;
`ifdef REGFILE_BYPASS_EN
        else if (wrEn && a == wrAddr) expRd[k] = wrData;
`endif
        else expRd[k] = refMem[a];
      end
      doWrite = wrEn && (wrAddr != 0);
    end
    @(posedge clk);
    #1;
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) refMem[i] = '0;
    end else if (doWrite) begin
      refMem[wrAddr] = wrData;
    end
    refReady = nextReady;
    checkOutput("ready", {31'd0, ready}, {31'd0, refReady});
    for (int k = 0; k < NREAD; k++) begin
      checkOutput($sformatf("rd_data[%0d]", k), portData(k), expRd[k]);
    end
  endtask

  function automatic void setIdle();
    wrEn   = 1'b0;
    wrAddr = '0;
    wrData = '0;
  endfunction

  initial begin
    checkCount     = 0;
    passCount      = 0;
    cyclesSinceRst = 0;
    refReady       = 1'b0;
    for (int i = 0; i < DEPTH; i++) refMem[i] = '0;
    for (int k = 0; k < NREAD; k++) expRd[k] = '0;
    rst    = 1'b1;
    rdAddr = '0;
    setIdle();

    // Reset held for two cycles
    applyStimulus();
    applyStimulus();
    checkOutput("reset_ready", {31'd0, ready}, 32'd0);
    checkOutput("reset_rd0", portData(0), 32'd0);

    // Sweep: a write to entry 31 during CLEAR must be dropped
    rst    = 1'b0;
    wrEn   = 1'b1;
    wrAddr = 5'd31;
    wrData = 32'h55;
    for (int c = 1; c <= DEPTH; c++) begin
      applyStimulus();
      if (c == DEPTH - 1) checkOutput("ready_low_31", {31'd0, ready}, 32'd0);
    end
    checkOutput("ready_high_32", {31'd0, ready}, 32'd1);
    setIdle();

    // Every entry reads zero, including 31
    for (int i = 0; i < DEPTH; i++) begin
      rdAddr = {5'(DEPTH - 1 - i), 5'(i)};
      applyStimulus();
    end
    checkOutput("sweep_write_dropped", portData(0), 32'd0);

    // Write then read on both ports
    wrEn = 1'b1; wrAddr = 5'd5; wrData = 32'hDEADBEEF;
    applyStimulus();
    setIdle();
    rdAddr = {5'd5, 5'd5};
    applyStimulus();
    checkOutput("wr_rd_p0", portData(0), 32'hDEADBEEF);
    checkOutput("wr_rd_p1", portData(1), 32'hDEADBEEF);

    // Zero register ignores writes
    wrEn = 1'b1; wrAddr = 5'd0; wrData = 32'h12345678;
    applyStimulus();
    setIdle();
    rdAddr = {5'd5, 5'd0};
    applyStimulus();
    checkOutput("zero_reg", portData(0), 32'd0);

    // Same-cycle collision on entry 7
    wrEn = 1'b1; wrAddr = 5'd7; wrData = 32'h1;
    applyStimulus();
    wrData = 32'h2; rdAddr = {5'd0, 5'd7};
    applyStimulus();
`ifdef REGFILE_BYPASS_EN
    checkOutput("collision", portData(0), 32'h2);
`else
    checkOutput("collision", portData(0), 32'h1);
`endif
    setIdle();
    applyStimulus();
    checkOutput("after_collision", portData(0), 32'h2);

    // Randomized traffic over a narrow address range to provoke collisions
    for (int n = 0; n < 300; n++) begin
      wrEn   = 1'($urandom_range(0, 1));
      wrAddr = 5'($urandom_range(0, 7));
      wrData = $urandom;
      rdAddr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      applyStimulus();
    end
    setIdle();

    // Reset mid-operation: restart again at sweep count 10
    wrEn = 1'b1; wrAddr = 5'd3; wrData = 32'hAA;
    applyStimulus();
    setIdle();
    rst = 1'b1;
    applyStimulus();
    rst = 1'b0;
    for (int c = 0; c < 10; c++) applyStimulus();
    rst = 1'b1;
    applyStimulus();
    rst = 1'b0;
    rdAddr = {5'd3, 5'd3};
    for (int c = 1; c <= DEPTH; c++) begin
      applyStimulus();
      if (c == DEPTH - 1) checkOutput("rst_mid_low", {31'd0, ready}, 32'd0);
    end
    checkOutput("rst_mid_high", {31'd0, ready}, 32'd1);
    applyStimulus();
    checkOutput("rst_mid_entry3", portData(1), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter WIDTH, default 32: bits per register entry.
REQ-002 SHALL have parameter DEPTH, default 32: number of entries, a power of two and at least 2; AW = log2(DEPTH).
REQ-003 SHALL have parameter NREAD, default 2: number of independent read ports, at least 1.
REQ-004 SHALL have parameter ZERO_REG, default 1: when 1, entry 0 is hardwired to zero.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port wr_en, input, 1 bit: write request.
REQ-008 SHALL have port wr_addr, input, AW bits: write index.
REQ-009 SHALL have port wr_data, input, WIDTH bits: write value.
REQ-010 SHALL have port rd_addr, input, NREAD*AW bits: read indices; port k occupies bits [k*AW +: AW].
REQ-011 SHALL have port rd_data, output, NREAD*WIDTH bits: registered read results; port k occupies bits [k*WIDTH +: WIDTH].
REQ-012 SHALL have port ready, output, 1 bit: 1 when the clear sweep has finished and the file accepts accesses.

Function
REQ-013 SHALL implement a two-state machine, CLEAR and RUN, plus an AW-bit sweep counter.
REQ-014 SHALL, in CLEAR, write zero to the entry selected by the sweep counter and then increment the counter on every cycle.
REQ-015 SHALL move from CLEAR to RUN on the cycle the counter clears entry DEPTH-1, so ready rises exactly DEPTH cycles after rst deasserts.
REQ-016 SHALL, in CLEAR, silently drop wr_en and drive every rd_data port to zero.
REQ-017 SHALL, in RUN, write wr_data to entry wr_addr on a clock edge where wr_en=1, except when ZERO_REG=1 and wr_addr=0, in which case the write is discarded.
REQ-018 SHALL update each rd_data port on every clock edge in RUN with the entry at that port's rd_addr, giving a one-cycle read latency.
REQ-019 SHALL return zero on any port reading entry 0 when ZERO_REG=1, whatever writes were attempted.
REQ-020 SHALL allow all NREAD ports to read the same or different addresses in the same cycle with no interaction between ports.
REQ-021 SHALL, when a read and a write hit the same address in the same cycle, return the old value unless bypass is compiled in (REQ-025).
REQ-022 SHALL keep ready constant at 1 in RUN until the next reset.

Reset
REQ-023 SHALL, on a clock edge with rst=1, enter CLEAR, set the counter to 0, drive ready to 0 and drive every rd_data port to zero.
REQ-024 SHALL, when rst is asserted during CLEAR or RUN, restart the sweep from entry 0, with a full DEPTH-cycle sweep after rst deasserts.

Configuration
REQ-025 SHALL, when REGFILE_BYPASS_EN is defined, return wr_data on any RUN read port whose rd_addr equals wr_addr while wr_en=1, except at entry 0 when ZERO_REG=1.
REQ-026 SHALL, when REGFILE_BYPASS_EN is undefined, contain no forwarding logic and behave as REQ-021 (read-before-write).

Verification
REQ-027 SHALL cover reset clear: defaults, rst high 2 cycles then low -> ready=0 for 32 cycles, 1 on cycle 32; all 32 entries read 0.
REQ-028 SHALL cover write then read: write 0xDEADBEEF to entry 5, next cycle rd_addr port0=5 and port1=5 -> both ports show 0xDEADBEEF one cycle later.
REQ-029 SHALL cover the zero register: write 0x12345678 to entry 0 -> a later read of entry 0 returns 0x00000000.
REQ-030 SHALL cover a same-cycle collision: entry 7 holds 0x1, write 0x2 to entry 7 while port0 reads 7 -> 0x1 without REGFILE_BYPASS_EN, 0x2 with it; the next read returns 0x2 in both builds.
REQ-031 SHALL cover reset mid-operation: write 0xAA to entry 3, assert rst at sweep count 10, release -> ready low for 32 cycles, then entry 3 reads 0.
REQ-032 SHALL cover writes during the sweep: wr_en=1 to entry 31 with 0x55 during CLEAR -> entry 31 reads 0 after ready.
